// File: rtl/sync_chain_filt_pkg.sv
// sync_chain_filt_pkg: shared limits and filter state encoding for sync_chain_filt
package sync_chain_filt_pkg;
  localparam int STAGES_MIN = 2;
  localparam int STAGES_MAX = 4;
  localparam int STABLE_MAX = 255;
  localparam int CNT_W = 8;
  typedef enum logic {IDLE, QUAL} state_t;
endpackage

// File: rtl/sync_chain_filt_sync_stage.sv
// sync_stage: single-bit multi-flop synchroniser chain with synchronous clear
module sync_stage #(
  parameter int STAGES = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic D,
  output logic Q
);
  logic [STAGES-1:0] ff;
  always_ff @(posedge CLK)
    ff <= RST ? '0 : {ff[STAGES-2:0], D};
  assign Q = ff[STAGES-1];
endmodule

// File: rtl/sync_chain_filt.sv
// sync_chain_filt: per-bit synchronisers plus stability filter; edge pulses when SYNC_CHAIN_FILT_EDGE_EN is defined
module sync_chain_filt
  import sync_chain_filt_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2,
  parameter int STABLE = 3
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] IDATA,
  output logic [WIDTH-1:0] ODATA,
  output logic             OCHG,
  output logic             OBUSY,
  output logic [WIDTH-1:0] ORISE,
  output logic [WIDTH-1:0] OFALL
);
  state_t state, state_nxt;
  logic [WIDTH-1:0] s, cand, cand_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_d;
  logic match, same, upd, done;
  if (STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad_stages
    $error("sync_chain_filt: STAGES %0d out of range", STAGES);
  end
  if (STABLE < 1 || STABLE > STABLE_MAX) begin : g_bad_stable
    $error("sync_chain_filt: STABLE %0d out of range", STABLE);
  end
  for (genvar i = 0; i < WIDTH; i++) begin : g_sync
    sync_stage #(.STAGES(STAGES)) u_sync (.CLK(CLK), .RST(RST), .D(IDATA[i]), .Q(s[i]));
  end
  // whole vector is one candidate, so accepted updates never mix bits
  always_comb begin
    match     = state == QUAL && s == cand;
    cnt_nxt   = match ? cnt + 1'b1 : CNT_W'(1);
    same      = s == ODATA;
    upd       = !same && cnt_nxt == CNT_W'(STABLE);
    done      = same || upd;
    state_nxt = done ? IDLE : QUAL;
    cand_nxt  = done ? cand : s;
    cnt_d     = done ? '0 : cnt_nxt;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      cand  <= '0;
      cnt   <= '0;
      ODATA <= '0;
      OCHG  <= 1'b0;
    end else begin
      state <= state_nxt;
      cand  <= cand_nxt;
      cnt   <= cnt_d;
      ODATA <= upd ? s : ODATA;
      OCHG  <= upd;
    end
  end
  assign OBUSY = state == QUAL;
`ifdef SYNC_CHAIN_FILT_EDGE_EN
  always_ff @(posedge CLK) begin
    ORISE <= RST || !upd ? '0 : s & ~ODATA;
    OFALL <= RST || !upd ? '0 : ~s & ODATA;
  end
`else
  assign ORISE = '0;
  assign OFALL = '0;
`endif
endmodule

// File: tb/tb_sync_chain_filt.sv
// tb_sync_chain_filt: directed table, corner sequences and randomized run against a window-based model
module tb_sync_chain_filt;
  localparam int STAGES = 2;
  localparam int STABLE = 3;
`ifdef SYNC_CHAIN_FILT_EDGE_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif
  typedef struct {
    logic [3:0] d;
    logic [3:0] od;
    logic       ch;
    logic       bz;
    logic [3:0] ri;
    logic [3:0] fa;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1;
  logic [3:0] idata = '0, idata1 = '0;
  logic [3:0] odata, rise, fall, odata1, rise1, fall1;
  logic ochg, busy, ochg1, busy1;
  int checks = 0, errors = 0;
  logic [3:0] pipe[$], win[$];
  logic [3:0] m_odata, m_rise, m_fall;
  logic m_ochg, m_busy;
  vec_t tbl[$];

  always #5 clk = ~clk;

  sync_chain_filt u_dut (.CLK(clk), .RST(rst), .IDATA(idata), .ODATA(odata), .OCHG(ochg),
                         .OBUSY(busy), .ORISE(rise), .OFALL(fall));
  sync_chain_filt #(.WIDTH(4), .STAGES(3), .STABLE(1)) u_dut1 (.CLK(clk), .RST(rst), .IDATA(idata1),
                         .ODATA(odata1), .OCHG(ochg1), .OBUSY(busy1), .ORISE(rise1), .OFALL(fall1));

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // output changes to v once the last STABLE observed synchronised values are all v and v differs
  task automatic model_edge(input logic r, input logic [3:0] d);
    logic [3:0] s, dummy;
    logic upd;
    if (r) begin
      pipe = {};
      repeat (STAGES) pipe.push_back(4'h0);
      win = {};
      m_odata = '0; m_ochg = 0; m_busy = 0; m_rise = '0; m_fall = '0;
      return;
    end
    s = pipe[0];
    pipe.push_back(d);
    dummy = pipe.pop_front();
    win.push_back(s);
    if (win.size() > STABLE) dummy = win.pop_front();
    upd = win.size() == STABLE && s != m_odata;
    foreach (win[i]) if (win[i] != s) upd = 0;
    m_ochg = upd;
    m_busy = !upd && s != m_odata;
    m_rise = upd ? s & ~m_odata : 4'h0;
    m_fall = upd ? ~s & m_odata : 4'h0;
    if (upd) m_odata = s;
  endtask

  task automatic step(input logic r, input logic [3:0] d);
    rst = r;
    idata = d;
    @(posedge clk);
    model_edge(r, d);
    #1;
    chk("m_odata", odata, m_odata);
    chk("m_ochg", {3'b0, ochg}, {3'b0, m_ochg});
    chk("m_busy", {3'b0, busy}, {3'b0, m_busy});
    chk("m_rise", rise, EDGE_EN ? m_rise : 4'h0);
    chk("m_fall", fall, EDGE_EN ? m_fall : 4'h0);
  endtask

  task automatic add(input logic [3:0] d, od, input logic ch, bz, input logic [3:0] ri, fa);
    vec_t e;
    e.d = d; e.od = od; e.ch = ch; e.bz = bz; e.ri = ri; e.fa = fa;
    tbl.push_back(e);
  endtask

  task automatic chk_vec(input string tag, input vec_t t);
    chk({tag, "_odata"}, odata, t.od);
    chk({tag, "_ochg"}, {3'b0, ochg}, {3'b0, t.ch});
    chk({tag, "_busy"}, {3'b0, busy}, {3'b0, t.bz});
    chk({tag, "_rise"}, rise, EDGE_EN ? t.ri : 4'h0);
    chk({tag, "_fall"}, fall, EDGE_EN ? t.fa : 4'h0);
  endtask

  initial begin
    int n;
    vec_t z;
    z.d = 0; z.od = 0; z.ch = 0; z.bz = 0; z.ri = 0; z.fa = 0;
    // 0 -> A held
    add(4'hA, 4'h0, 0, 0, 4'h0, 4'h0); add(4'hA, 4'h0, 0, 0, 4'h0, 4'h0);
    add(4'hA, 4'h0, 0, 1, 4'h0, 4'h0); add(4'hA, 4'h0, 0, 1, 4'h0, 4'h0);
    add(4'hA, 4'hA, 1, 0, 4'hA, 4'h0); add(4'hA, 4'hA, 0, 0, 4'h0, 4'h0);
    // A -> 5 held
    add(4'h5, 4'hA, 0, 0, 4'h0, 4'h0); add(4'h5, 4'hA, 0, 0, 4'h0, 4'h0);
    add(4'h5, 4'hA, 0, 1, 4'h0, 4'h0); add(4'h5, 4'hA, 0, 1, 4'h0, 4'h0);
    add(4'h5, 4'h5, 1, 0, 4'h5, 4'hA); add(4'h5, 4'h5, 0, 0, 4'h0, 4'h0);
    // back to 0
    add(4'h0, 4'h5, 0, 0, 4'h0, 4'h0); add(4'h0, 4'h5, 0, 0, 4'h0, 4'h0);
    add(4'h0, 4'h5, 0, 1, 4'h0, 4'h0); add(4'h0, 4'h5, 0, 1, 4'h0, 4'h0);
    add(4'h0, 4'h0, 1, 0, 4'h0, 4'h5); add(4'h0, 4'h0, 0, 0, 4'h0, 4'h0);
    // two-cycle glitch to 5 is rejected
    add(4'h5, 4'h0, 0, 0, 4'h0, 4'h0); add(4'h5, 4'h0, 0, 0, 4'h0, 4'h0);
    add(4'h0, 4'h0, 0, 1, 4'h0, 4'h0); add(4'h0, 4'h0, 0, 1, 4'h0, 4'h0);
    add(4'h0, 4'h0, 0, 0, 4'h0, 4'h0); add(4'h0, 4'h0, 0, 0, 4'h0, 4'h0);
    // 3 for two cycles then 7: count restarts, only 7 accepted
    add(4'h3, 4'h0, 0, 0, 4'h0, 4'h0); add(4'h3, 4'h0, 0, 0, 4'h0, 4'h0);
    add(4'h7, 4'h0, 0, 1, 4'h0, 4'h0); add(4'h7, 4'h0, 0, 1, 4'h0, 4'h0);
    add(4'h7, 4'h0, 0, 1, 4'h0, 4'h0); add(4'h7, 4'h0, 0, 1, 4'h0, 4'h0);
    add(4'h7, 4'h7, 1, 0, 4'h7, 4'h0); add(4'h7, 4'h7, 0, 0, 4'h0, 4'h0);

    step(1, 4'h0);
    step(1, 4'h0);
    chk_vec("reset", z);
    step(0, 4'h0);
    chk_vec("post_reset", z);
    foreach (tbl[i]) begin
      step(0, tbl[i].d);
      chk_vec("tbl", tbl[i]);
    end

    // reset while qualifying C discards it; C then qualifies anew
    repeat (3) step(0, 4'hC);
    chk("qual_busy", {3'b0, busy}, 4'h1);
    step(1, 4'hC);
    chk_vec("mid_reset", z);
    n = 0;
    for (int i = 1; i <= 20 && n == 0; i++) begin
      step(0, 4'hC);
      if (ochg) n = i;
    end
    checks++;
    if (n != STAGES + STABLE) begin
      errors++;
      $display("FAIL requal_latency got %0d expected %0d", n, STAGES + STABLE);
    end
    chk("requal_odata", odata, 4'hC);

    // STAGES=3 STABLE=1 instance: 0 -> F
    idata1 = 4'hF;
    for (int i = 0; i < 6; i++) begin
      step(0, 4'hC);
      chk("s1_odata", odata1, i >= 3 ? 4'hF : 4'h0);
      chk("s1_ochg", {3'b0, ochg1}, {3'b0, i == 3});
      chk("s1_busy", {3'b0, busy1}, 4'h0);
      chk("s1_rise", rise1, EDGE_EN && i == 3 ? 4'hF : 4'h0);
      chk("s1_fall", fall1, 4'h0);
    end

    for (int k = 0; k < 800; k++) begin
      logic [3:0] d;
      d = 4'($urandom);
      repeat ($urandom_range(1, 5)) step($urandom_range(0, 63) == 0, d);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
